// File: rtl/sram_frame_reader.sv
// Display-side frame reader: walks the linear RGB444 frame in SRAM with VGA timing
// and streams it to the DAC through a fixed two-register pipeline.
module sram_frame_reader #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter logic [19:0] BASE_ADDR = 20'd0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_bus_gnt,
    output logic [19:0] o_sram_addr,
    output logic        o_sram_oe_n,
    output logic        o_sram_we_n,
    input  logic [15:0] i_sram_dq,
    output logic [7:0]  o_vga_r,
    output logic [7:0]  o_vga_g,
    output logic [7:0]  o_vga_b,
    output logic        o_vga_hs,
    output logic        o_vga_vs,
    output logic        o_vga_blank_n,
    output logic        o_frame_start,
    output logic        o_underrun
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEGIN  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEGIN  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_cnt_reg;
    logic [VW-1:0] v_cnt_reg;
    logic [18:0]   addr_cnt_reg;
    logic [19:0]   addr_hold_reg;

    logic          line_end, frame_end;
    logic          active_s0, hs_s0, vs_s0, fs_s0, rd_en;
    logic [19:0]   rd_addr;

    logic [11:0]   data_q_reg;
    logic          valid_q_reg, hs_q_reg, vs_q_reg, blank_q_reg, fs_q_reg;

    logic [7:0]    expand_next [3];
    logic [7:0]    vga_r_reg, vga_g_reg, vga_b_reg;
    logic          vga_hs_reg, vga_vs_reg, vga_blank_reg, frame_start_reg;
    logic          underrun_reg;
    logic          dq_unused;

    // Stage 0: decode the raster position the counters point at this cycle.
    assign line_end  = (h_cnt_reg == H_LAST);
    assign frame_end = line_end && (v_cnt_reg == V_LAST);
    assign active_s0 = (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
    assign hs_s0     = !((h_cnt_reg >= HS_BEGIN) && (h_cnt_reg < HS_END));
    assign vs_s0     = !((v_cnt_reg >= VS_BEGIN) && (v_cnt_reg < VS_END));
    assign fs_s0     = (h_cnt_reg == '0) && (v_cnt_reg == '0);

    // Reset gates the read strobe so the SRAM is released while held in reset,
    // even though (0,0) is an active position.
    assign rd_en   = active_s0 && i_bus_gnt && i_rst_n;
    assign rd_addr = BASE_ADDR + 20'(addr_cnt_reg);

    assign o_sram_addr = rd_en ? rd_addr : addr_hold_reg;
    assign o_sram_oe_n = !rd_en;
    assign o_sram_we_n = 1'b1;
    assign dq_unused   = &{1'b0, i_sram_dq[3:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (line_end) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= frame_end ? '0 : v_cnt_reg + VW'(1);
        end else begin
            h_cnt_reg <= h_cnt_reg + HW'(1);
        end
    end

    // The address advances on every active pixel regardless of grant, so a
    // lost grant drops that pixel instead of shifting the rest of the frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_cnt_reg  <= '0;
            addr_hold_reg <= BASE_ADDR;
            underrun_reg  <= 1'b0;
        end else begin
            if (frame_end)
                addr_cnt_reg <= '0;
            else if (active_s0)
                addr_cnt_reg <= addr_cnt_reg + 19'd1;
            if (rd_en)
                addr_hold_reg <= rd_addr;
            if (active_s0 && !i_bus_gnt)
                underrun_reg <= 1'b1;
        end
    end

    // Stage 1: capture the asynchronous SRAM data alongside its timing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q_reg  <= '0;
            valid_q_reg <= 1'b0;
            hs_q_reg    <= 1'b1;
            vs_q_reg    <= 1'b1;
            blank_q_reg <= 1'b0;
            fs_q_reg    <= 1'b0;
        end else begin
            data_q_reg  <= i_sram_dq[15:4];
            valid_q_reg <= rd_en;
            hs_q_reg    <= hs_s0;
            vs_q_reg    <= vs_s0;
            blank_q_reg <= active_s0;
            fs_q_reg    <= fs_s0;
        end
    end

    // Nibble replication maps 4'hF to 8'hFF and 4'h0 to 8'h00 exactly.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_expand
            assign expand_next[gi] = valid_q_reg ? {2{data_q_reg[11-4*gi -: 4]}} : 8'h00;
        end
    endgenerate

    // Stage 2: registered outputs, all carrying the same two-clock delay.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vga_r_reg       <= '0;
            vga_g_reg       <= '0;
            vga_b_reg       <= '0;
            vga_hs_reg      <= 1'b1;
            vga_vs_reg      <= 1'b1;
            vga_blank_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            vga_r_reg       <= expand_next[0];
            vga_g_reg       <= expand_next[1];
            vga_b_reg       <= expand_next[2];
            vga_hs_reg      <= hs_q_reg;
            vga_vs_reg      <= vs_q_reg;
            vga_blank_reg   <= blank_q_reg;
            frame_start_reg <= fs_q_reg;
        end
    end

    assign o_vga_r       = vga_r_reg;
    assign o_vga_g       = vga_g_reg;
    assign o_vga_b       = vga_b_reg;
    assign o_vga_hs      = vga_hs_reg;
    assign o_vga_vs      = vga_vs_reg;
    assign o_vga_blank_n = vga_blank_reg;
    assign o_frame_start = frame_start_reg;
    assign o_underrun    = underrun_reg;

endmodule
